// File: rtl/tof_pll_pkg.sv
// Shared definitions for the ToF PLL serial writer and its init sequencer.
package tof_pll_pkg;

  localparam int WORD_BITS = 24;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    SETUP,
    LOAD,
    HOLD
  } state_t;

  // Power-up register words, sent in this order by the init sequencer.
  localparam logic [WORD_BITS-1:0] PLL_INIT_WORD0 = 24'h34002D;
  localparam logic [WORD_BITS-1:0] PLL_INIT_WORD1 = 24'h0481A4;
  localparam logic [WORD_BITS-1:0] PLL_INIT_WORD2 = 24'h002C0A;

endpackage

// File: rtl/tof_pll_spi_writer.sv
// Shifts one 24-bit word MSB first into the PLL on pll_sclk_o/pll_sdin_o,
// then pulses pll_load_o to latch it.
module tof_pll_spi_writer
  import tof_pll_pkg::*;
#(
  parameter int CLKDIV      = 4,
  parameter int LOAD_CYCLES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [WORD_BITS-1:0] word_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 done_o,
  output logic                 pll_sclk_o,
  output logic                 pll_sdin_o,
  output logic                 pll_load_o
);

  localparam logic [7:0] HALF_RELOAD = 8'(CLKDIV - 1);
  localparam logic [7:0] LOAD_RELOAD = 8'(LOAD_CYCLES - 1);
  localparam logic [4:0] LAST_BIT    = 5'(WORD_BITS - 1);

  state_t               state;
  logic [7:0]           phase_cnt;
  logic [4:0]           bit_cnt;
  logic [WORD_BITS-1:0] shift_reg;
  logic                 phase_end;

  assign phase_end = (phase_cnt == 8'd0);

  // The shift register MSB is the data pin; the final shift after the last
  // bit empties it, which gives the zero data required during SETUP.
  assign pll_sdin_o = shift_reg[WORD_BITS-1];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      phase_cnt  <= 8'd0;
      bit_cnt    <= 5'd0;
      shift_reg  <= '0;
      ready_o    <= 1'b0;
      done_o     <= 1'b0;
      pll_sclk_o <= 1'b0;
      pll_load_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i && ready_o) begin
            shift_reg <= word_i;
            bit_cnt   <= LAST_BIT;
            phase_cnt <= HALF_RELOAD;
            ready_o   <= 1'b0;
            state     <= SHIFT_LO;
          end else begin
            ready_o <= 1'b1;
          end
        end

        SHIFT_LO: begin
          if (phase_end) begin
            pll_sclk_o <= 1'b1;
            phase_cnt  <= HALF_RELOAD;
            state      <= SHIFT_HI;
          end else begin
            phase_cnt <= phase_cnt - 8'd1;
          end
        end

        SHIFT_HI: begin
          if (phase_end) begin
            pll_sclk_o <= 1'b0;
            phase_cnt  <= HALF_RELOAD;
            shift_reg  <= {shift_reg[WORD_BITS-2:0], 1'b0};
            if (bit_cnt != 5'd0) begin
              bit_cnt <= bit_cnt - 5'd1;
              state   <= SHIFT_LO;
            end else begin
              state <= SETUP;
            end
          end else begin
            phase_cnt <= phase_cnt - 8'd1;
          end
        end

        SETUP: begin
          if (phase_end) begin
            pll_load_o <= 1'b1;
            phase_cnt  <= LOAD_RELOAD;
            state      <= LOAD;
          end else begin
            phase_cnt <= phase_cnt - 8'd1;
          end
        end

        LOAD: begin
          if (phase_end) begin
            pll_load_o <= 1'b0;
            phase_cnt  <= HALF_RELOAD;
            done_o     <= (HALF_RELOAD == 8'd0);
            state      <= HOLD;
          end else begin
            phase_cnt <= phase_cnt - 8'd1;
          end
        end

        HOLD: begin
          // done_o is raised one edge early so it is high in the final HOLD cycle.
          if (phase_end) begin
            done_o  <= 1'b0;
            ready_o <= 1'b1;
            state   <= IDLE;
          end else begin
            phase_cnt <= phase_cnt - 8'd1;
            done_o    <= (phase_cnt == 8'd1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/tof_pll_spi_writer.md
TOF_PLL_SPI_WRITER -- requirements
Module: tof_pll_spi_writer

Interface
REQ-001 Parameter CLKDIV, default 4: SCLK half-period in clk_i cycles; legal range 1..255.
REQ-002 Parameter LOAD_CYCLES, default 4: width of the pll_load_o pulse in clk_i cycles; legal range 1..255.
REQ-003 Clock and reset: one clock, clk_i; reset is asynchronous and active-low, rst_n_i.
REQ-004 clk_i  input  1  system clock; all logic is rising-edge.
REQ-005 rst_n_i  input  1  asynchronous active-low reset.
REQ-006 word_i  input  24  PLL register word to send, MSB first.
REQ-007 valid_i  input  1  word_i is valid.
REQ-008 ready_o  output  1  writer idle; the word is accepted on valid_i && ready_o.
REQ-009 done_o  output  1  one-cycle pulse at the end of a complete write.
REQ-010 pll_sclk_o  output  1  PLL serial clock.
REQ-011 pll_sdin_o  output  1  PLL serial data.
REQ-012 pll_load_o  output  1  PLL latch enable, active-high pulse.

Function
REQ-013 States: IDLE, SHIFT_LO, SHIFT_HI, SETUP, LOAD, HOLD.
REQ-014 Handshake and capture:
- ready_o = 1 only in IDLE.
- On the accepting edge, word_i is copied into a 24-bit shift register and a 5-bit bit counter is set to 23.
- The FSM then goes to SHIFT_LO.
REQ-015 SHIFT_LO lasts CLKDIV cycles:
- pll_sclk_o = 0.
- pll_sdin_o = shift-register MSB, stable for the whole bit period.
REQ-016 SHIFT_HI lasts CLKDIV cycles:
- pll_sclk_o = 1; the PLL samples on this rising edge.
- On exit, if the bit counter is non-zero: decrement it, shift left, return to SHIFT_LO.
- On exit with the counter at 0: go to SETUP.
REQ-017 SETUP lasts CLKDIV cycles: pll_sclk_o = 0, pll_sdin_o = 0.
REQ-018 LOAD lasts LOAD_CYCLES cycles: pll_load_o = 1.
REQ-019 HOLD lasts CLKDIV cycles: pll_load_o = 0.
REQ-020 Exit from HOLD: done_o is high for the last HOLD cycle, then the FSM returns to IDLE.
REQ-021 Timing: from the accept edge to the done_o cycle is exactly 48*CLKDIV + CLKDIV + LOAD_CYCLES + CLKDIV cycles (204 cycles for the defaults).
REQ-022 Exactly 24 rising edges of pll_sclk_o occur per word; pll_sclk_o and pll_load_o are never high in the same cycle.
REQ-023 valid_i while not in IDLE is ignored: no queueing, no corruption of the word in flight. Changes to word_i after acceptance have no effect.
REQ-024 Back-to-back operation: valid_i high in the first IDLE cycle after done_o is accepted in that cycle, so there are no dead cycles beyond one IDLE cycle.
REQ-025 Phase counter:
- One 8-bit counter times every phase; it reloads on every state change.
- CLKDIV = 1 gives a 2-cycle SCLK period with no skipped or extra edges.
REQ-026 All outputs are registered; there are no combinational paths from inputs to outputs.

Reset
REQ-027 rst_n_i low forces, asynchronously and at any time including mid-shift or mid-LOAD:
- state = IDLE;
- pll_sclk_o, pll_sdin_o, pll_load_o, done_o = 0;
- counters and shift register = 0.
REQ-028 ready_o is 0 while rst_n_i is low and 1 on the first clk_i edge after release.
REQ-029 A write cut by reset is not resumed; no partial pll_load_o pulse is generated after reset.

Structure
REQ-030 Package tof_pll_pkg contains: the WORD_BITS = 24 constant, the state enumeration, and the three PLL init word constants shared with the init sequencer.
REQ-031 The block is a single module with no sub-modules. The init sequencer instantiates it and drives word_i/valid_i from its word list.

Verification
REQ-032 Single word: word_i = 0x34002D, defaults.
- Bits sampled on each pll_sclk_o rise = 0011_0100_0000_0000_0010_1101 in order.
- pll_load_o high for exactly 4 cycles starting at cycle 196.
- done_o at cycle 203 after acceptance, where the accept edge is cycle 0.
REQ-033 Sequence: 0x34002D, 0x0481A4, 0x002C0A sent back-to-back with valid_i held high.
- Three load pulses; each latched word is correct.
- ready_o is high for exactly one cycle between words.
REQ-034 Busy input: valid_i pulses with word_i = 0xFFFFFF during SHIFT states of word 0x000000.
- Only 0x000000 is shifted.
- No second write occurs.
REQ-035 Reset mid-write: rst_n_i low at bit 10 of 0x0481A4.
- All PLL outputs are 0 within the same cycle.
- No load pulse; ready_o = 1 one cycle after release.
REQ-036 CLKDIV = 1, LOAD_CYCLES = 1, word 0xAAAAAA:
- pll_sclk_o toggles every cycle for 24 periods.
- done_o at cycle 50.
